instruction_refill_controller: RTL and testbench
================================================

Name: instruction_refill_controller

Overview:
- Sits directly downstream of the L1 instruction cache, on its miss path. It serves the cache's block-refill request.
- Accepts one word-aligned miss address from L1 over a valid/ready handshake and aligns it to the block boundary.
- Issues WORD_PER_BLOCK single-word reads to the backing memory and assembles the returned words in a line buffer.
- Returns the complete block to L1 over a valid/ready handshake. One refill is in flight at a time.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width; word addresses are ADDRESS_WIDTH-2 bits.
- DATA_WIDTH, 32, width of one memory word.
- WORD_PER_BLOCK, 16, words per cache block; must be a power of two, at least 2.
- MAX_OUTSTANDING, 4, maximum memory reads issued but not yet answered; must be between 1 and WORD_PER_BLOCK.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ADDRESS_FROM_L1_VALID  in  1  miss request valid.
- ADDRESS_FROM_L1_READY  out  1  controller can accept a miss request.
- ADDRESS_FROM_L1  in  ADDRESS_WIDTH-2  word address of the missed instruction.
- DATA_TO_L1_VALID  out  1  assembled block valid.
- DATA_TO_L1_READY  in  1  L1 accepts the block.
- DATA_TO_L1  out  WORD_PER_BLOCK*DATA_WIDTH  block; word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- MEM_REQ_VALID  out  1  read request valid.
- MEM_REQ_READY  in  1  memory accepts the request.
- MEM_REQ_ADDRESS  out  ADDRESS_WIDTH-2  word address to read.
- MEM_RESP_VALID  in  1  read data valid; responses return in request order; no backpressure.
- MEM_RESP_DATA  in  DATA_WIDTH  read data.

Behaviour:
- Reset: the clock is CLK; RST_N is asynchronous and active-low.
  - On reset: state IDLE; ADDRESS_FROM_L1_READY=1; DATA_TO_L1_VALID=0; MEM_REQ_VALID=0.
  - MEM_REQ_ADDRESS=0; DATA_TO_L1=0; all counters 0.
  - Reset mid-refill abandons the refill; nothing is returned to L1.
- States: IDLE, FILL, DELIVER.
- IDLE:
  - ADDRESS_FROM_L1_READY=1.
  - On VALID&READY: capture the block base (ADDRESS_FROM_L1 with its low log2(WORD_PER_BLOCK) bits cleared) and the requested word offset.
  - Clear the issue and receive counters; go to FILL.
  - MEM_RESP_VALID in IDLE is ignored.
- FILL:
  - ADDRESS_FROM_L1_READY=0.
  - MEM_REQ_VALID=1 while issue count < WORD_PER_BLOCK and outstanding < MAX_OUTSTANDING.
  - MEM_REQ_ADDRESS = base + issue order index; the order index is set by the optional feature below.
  - issue count increments on MEM_REQ_VALID&MEM_REQ_READY.
  - Each MEM_RESP_VALID writes MEM_RESP_DATA into the line-buffer slot of the matching issue order and increments the receive count.
  - outstanding = issue count − receive count, with width log2(WORD_PER_BLOCK)+1.
  - A request issue and a response in the same cycle leave outstanding unchanged.
  - When the final response arrives, go to DELIVER the next cycle.
- DELIVER:
  - DATA_TO_L1_VALID=1; DATA_TO_L1 is held stable until accepted.
  - On DATA_TO_L1_READY, return to IDLE; ADDRESS_FROM_L1_READY rises the cycle after the handshake.
- Order index wraps modulo WORD_PER_BLOCK; a block never crosses its aligned boundary.
- Minimum latency, from the address handshake to DATA_TO_L1_VALID, with zero-wait memory (request ready always, response one cycle after the request): WORD_PER_BLOCK+2 cycles.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- With the macro defined:
  - Requests start at the missed word offset and wrap: offset, offset+1, …, offset−1 (mod WORD_PER_BLOCK).
  - Adds output CRITICAL_WORD_VALID (1 bit) and output CRITICAL_WORD (DATA_WIDTH). Both reset to 0.
  - CRITICAL_WORD_VALID pulses for one cycle, registered, the cycle after the first response; CRITICAL_WORD holds that response's data.
- Without the macro: requests run linearly from word 0; the offset is unused; the critical-word ports do not exist.
- The assembled block content is identical in both builds.

Decomposition:
- Shared package:
  - state enum (IDLE/FILL/DELIVER);
  - localparams WORD_SELECT=$clog2(WORD_PER_BLOCK) and L1_BLOCK_WIDTH=WORD_PER_BLOCK*DATA_WIDTH;
  - word-address width constant.
- One natural sub-module: refill_line_buffer. It holds WORD_PER_BLOCK×DATA_WIDTH registers with an indexed word write and a flat block read, cleared on reset.

Test Plan:
- Linear refill, macro off, zero-wait memory: ADDRESS_FROM_L1=0x00000123 → requests 0x120..0x12F in order; DATA_TO_L1 word i = response i; DATA_TO_L1_VALID at cycle 18 after the handshake.
- Critical-word-first, macro on, address 0x00000127:
  - requests 0x127..0x12F then 0x120..0x126;
  - CRITICAL_WORD_VALID pulses with data of 0x127;
  - block word 7 = that data.
- Backpressure:
  - MEM_REQ_READY low for 5 cycles mid-fill → MEM_REQ_ADDRESS stable, no duplicate or lost word;
  - DATA_TO_L1_READY low for 10 cycles → DATA_TO_L1 stable, ADDRESS_FROM_L1_READY stays 0.
- Outstanding limit: MAX_OUTSTANDING=4, responses delayed 8 cycles → at most 4 requests issued before the first response; issue resumes as responses arrive.
- Reset mid-FILL after 6 responses: RST_N low → all outputs at reset values immediately; after release, a new refill completes correctly and late stale responses in IDLE are ignored.
- Back-to-back misses: new ADDRESS_FROM_L1_VALID held during DELIVER → not accepted until the cycle after the DATA_TO_L1 handshake; the second block is correct.

Source files
------------

// File: rtl/instruction_refill_controller_pkg.sv
// Shared types and default sizing for the L1 instruction-cache refill controller.
package instruction_refill_controller_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH   = 32;
    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_WORD_PER_BLOCK  = 16;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    localparam int unsigned WORD_SELECT        = $clog2(DEF_WORD_PER_BLOCK);
    localparam int unsigned L1_BLOCK_WIDTH     = DEF_WORD_PER_BLOCK * DEF_DATA_WIDTH;
    localparam int unsigned WORD_ADDRESS_WIDTH = DEF_ADDRESS_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DELIVER = 2'd2
    } refill_state_t;

endpackage

// File: rtl/instruction_refill_controller_refill_line_buffer.sv
// Line buffer collecting one cache block: indexed word write, flat block read.
module refill_line_buffer
    import instruction_refill_controller_pkg::*;
#(
    parameter int unsigned WORD_PER_BLOCK = DEF_WORD_PER_BLOCK,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned WORD_SELECT    = $clog2(WORD_PER_BLOCK)
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 wr_en,
    input  logic [WORD_SELECT-1:0]               wr_index,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic [WORD_PER_BLOCK*DATA_WIDTH-1:0] block
);

    // One comparator per slot keeps the write decode simple and width-exact.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            block <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < WORD_PER_BLOCK; i++) begin
                if (wr_index == WORD_SELECT'(i)) begin
                    block[i*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/instruction_refill_controller.sv
// Refills one L1 instruction-cache block from backing memory, one refill at a time.
// CRITICAL_WORD_FIRST_EN: fetch starting at the missed word and report it early.
module instruction_refill_controller
    import instruction_refill_controller_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned WORD_PER_BLOCK  = DEF_WORD_PER_BLOCK,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 ADDRESS_FROM_L1_VALID,
    output logic                                 ADDRESS_FROM_L1_READY,
    input  logic [ADDRESS_WIDTH-3:0]             ADDRESS_FROM_L1,
    output logic                                 DATA_TO_L1_VALID,
    input  logic                                 DATA_TO_L1_READY,
    output logic [WORD_PER_BLOCK*DATA_WIDTH-1:0] DATA_TO_L1,
    output logic                                 MEM_REQ_VALID,
    input  logic                                 MEM_REQ_READY,
    output logic [ADDRESS_WIDTH-3:0]             MEM_REQ_ADDRESS,
    input  logic                                 MEM_RESP_VALID,
    input  logic [DATA_WIDTH-1:0]                MEM_RESP_DATA
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                                 CRITICAL_WORD_VALID,
    output logic [DATA_WIDTH-1:0]                CRITICAL_WORD
`endif
);

    localparam int unsigned SEL_W   = $clog2(WORD_PER_BLOCK);
    localparam int unsigned CNT_W   = SEL_W + 1;
    localparam int unsigned WADDR_W = ADDRESS_WIDTH - 2;

    localparam logic [CNT_W-1:0]   WORDS       = CNT_W'(WORD_PER_BLOCK);
    localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(WORD_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0]   MAX_OUT     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WADDR_W-1:0] OFFSET_MASK = WADDR_W'(WORD_PER_BLOCK - 1);

    refill_state_t      state_q, state_d;
    logic [CNT_W-1:0]   issue_q, issue_d;
    logic [CNT_W-1:0]   recv_q, recv_d;
    logic [CNT_W-1:0]   outstanding_d;
    logic [WADDR_W-1:0] base_q, base_d;
    logic [SEL_W-1:0]   start_q;
    logic [SEL_W-1:0]   miss_start;
    logic [SEL_W-1:0]   issue_idx;
    logic [SEL_W-1:0]   buf_wr_index;
    logic               buf_wr_en;
    logic               req_fire;
    logic               l1_ready_d;
    logic               blk_valid_d;
    logic               req_valid_d;
    logic [WADDR_W-1:0] req_addr_d;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [SEL_W-1:0]      start_d;
    logic                  crit_valid_d;
    logic [DATA_WIDTH-1:0] crit_data_d;

    assign miss_start = ADDRESS_FROM_L1[SEL_W-1:0];
`else
    // Linear fill always starts at word 0 of the block.
    assign miss_start = '0;
    assign start_q    = '0;
`endif

    assign req_fire = MEM_REQ_VALID && MEM_REQ_READY;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d       = state_q;
        issue_d       = issue_q;
        recv_d        = recv_q;
        base_d        = base_q;
        outstanding_d = '0;
        issue_idx     = '0;
        l1_ready_d    = ADDRESS_FROM_L1_READY;
        blk_valid_d   = DATA_TO_L1_VALID;
        req_valid_d   = 1'b0;
        req_addr_d    = MEM_REQ_ADDRESS;
        buf_wr_en     = 1'b0;
        buf_wr_index  = start_q + recv_q[SEL_W-1:0];
`ifdef CRITICAL_WORD_FIRST_EN
        start_d       = start_q;
        crit_valid_d  = 1'b0;
        crit_data_d   = CRITICAL_WORD;
`endif

        unique case (state_q)
            IDLE: begin
                if (ADDRESS_FROM_L1_VALID && ADDRESS_FROM_L1_READY) begin
                    base_d      = ADDRESS_FROM_L1 & ~OFFSET_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d     = miss_start;
`endif
                    issue_d     = '0;
                    recv_d      = '0;
                    l1_ready_d  = 1'b0;
                    req_valid_d = 1'b1;
                    req_addr_d  = base_d + WADDR_W'(miss_start);
                    state_d     = FILL;
                end
            end

            FILL: begin
                if (req_fire) begin
                    issue_d = issue_q + CNT_W'(1);
                end
                if (MEM_RESP_VALID) begin
                    buf_wr_en = 1'b1;
                    recv_d    = recv_q + CNT_W'(1);
`ifdef CRITICAL_WORD_FIRST_EN
                    if (recv_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = MEM_RESP_DATA;
                    end
`endif
                end
                // Request valid for the coming cycle is judged on the updated counts.
                outstanding_d = issue_d - recv_d;
                issue_idx     = start_q + issue_d[SEL_W-1:0];
                req_valid_d   = (issue_d < WORDS) && (outstanding_d < MAX_OUT);
                req_addr_d    = base_q + WADDR_W'(issue_idx);
                if (MEM_RESP_VALID && (recv_q == LAST_WORD)) begin
                    req_valid_d = 1'b0;
                    blk_valid_d = 1'b1;
                    state_d     = DELIVER;
                end
            end

            DELIVER: begin
                if (DATA_TO_L1_READY) begin
                    blk_valid_d = 1'b0;
                    l1_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                blk_valid_d = 1'b0;
                l1_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q               <= IDLE;
            issue_q               <= '0;
            recv_q                <= '0;
            base_q                <= '0;
            ADDRESS_FROM_L1_READY <= 1'b1;
            DATA_TO_L1_VALID      <= 1'b0;
            MEM_REQ_VALID         <= 1'b0;
            MEM_REQ_ADDRESS       <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q               <= '0;
            CRITICAL_WORD_VALID   <= 1'b0;
            CRITICAL_WORD         <= '0;
`endif
        end else begin
            state_q               <= state_d;
            issue_q               <= issue_d;
            recv_q                <= recv_d;
            base_q                <= base_d;
            ADDRESS_FROM_L1_READY <= l1_ready_d;
            DATA_TO_L1_VALID      <= blk_valid_d;
            MEM_REQ_VALID         <= req_valid_d;
            MEM_REQ_ADDRESS       <= req_addr_d;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q               <= start_d;
            CRITICAL_WORD_VALID   <= crit_valid_d;
            CRITICAL_WORD         <= crit_data_d;
`endif
        end
    end

    refill_line_buffer #(
        .WORD_PER_BLOCK (WORD_PER_BLOCK),
        .DATA_WIDTH     (DATA_WIDTH),
        .WORD_SELECT    (SEL_W)
    ) u_line_buffer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr_en    (buf_wr_en),
        .wr_index (buf_wr_index),
        .wr_data  (MEM_RESP_DATA),
        .block    (DATA_TO_L1)
    );

endmodule

// File: tb/tb_instruction_refill_controller.sv
// Randomized scoreboard bench for instruction_refill_controller with a queue-based memory model.
module tb_instruction_refill_controller;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned WPB  = 16;
    localparam int unsigned MAXO = 4;
    localparam int unsigned WAW  = AW - 2;
    localparam int unsigned BW   = WPB * DW;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           ADDRESS_FROM_L1_VALID = 1'b0;
    logic           ADDRESS_FROM_L1_READY;
    logic [WAW-1:0] ADDRESS_FROM_L1 = '0;
    logic           DATA_TO_L1_VALID;
    logic           DATA_TO_L1_READY = 1'b1;
    logic [BW-1:0]  DATA_TO_L1;
    logic           MEM_REQ_VALID;
    logic           MEM_REQ_READY = 1'b1;
    logic [WAW-1:0] MEM_REQ_ADDRESS;
    logic           MEM_RESP_VALID = 1'b0;
    logic [DW-1:0]  MEM_RESP_DATA = '0;
`ifdef CRITICAL_WORD_FIRST_EN
    logic           CRITICAL_WORD_VALID;
    logic [DW-1:0]  CRITICAL_WORD;
`endif

    always #5 CLK = ~CLK;

    instruction_refill_controller #(
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .WORD_PER_BLOCK  (WPB),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .ADDRESS_FROM_L1_VALID (ADDRESS_FROM_L1_VALID),
        .ADDRESS_FROM_L1_READY (ADDRESS_FROM_L1_READY),
        .ADDRESS_FROM_L1       (ADDRESS_FROM_L1),
        .DATA_TO_L1_VALID      (DATA_TO_L1_VALID),
        .DATA_TO_L1_READY      (DATA_TO_L1_READY),
        .DATA_TO_L1            (DATA_TO_L1),
        .MEM_REQ_VALID         (MEM_REQ_VALID),
        .MEM_REQ_READY         (MEM_REQ_READY),
        .MEM_REQ_ADDRESS       (MEM_REQ_ADDRESS),
        .MEM_RESP_VALID        (MEM_RESP_VALID),
        .MEM_RESP_DATA         (MEM_RESP_DATA)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .CRITICAL_WORD_VALID   (CRITICAL_WORD_VALID),
        .CRITICAL_WORD         (CRITICAL_WORD)
`endif
    );

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } resp_t;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    resp_t          resp_q[$];
    logic [BW-1:0]  blk_q[$];
    logic [WAW-1:0] req_q[$];
    logic [DW-1:0]  crit_q[$];

    bit          mem_rand = 1'b0;
    bit          resp_rand = 1'b0;
    int unsigned resp_delay = 0;
    int          mem_stall = 0;
    bit          l1_block = 1'b0;
    bit          l1_rand = 1'b0;

    bit             busy = 1'b0;
    int             tb_issued = 0;
    int             tb_recv = 0;
    int unsigned    hs_cyc = 0;
    bit             lat_chk = 1'b0;
    bit             lat_seen = 1'b0;
    bit             req_stalled = 1'b0;
    logic [WAW-1:0] req_prev = '0;
    bit             blk_stalled = 1'b0;
    logic [BW-1:0]  blk_prev = '0;
    bit             crit_due = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [WAW-1:0] a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h3C5A_0F00;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Memory model: in-order responses after a programmable delay, optional request stalls.
    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                MEM_RESP_VALID = 1'b1;
                MEM_RESP_DATA  = resp_q[0].data;
                void'(resp_q.pop_front());
            end else begin
                MEM_RESP_VALID = 1'b0;
                MEM_RESP_DATA  = $urandom;
            end
            if (mem_stall > 0) begin
                MEM_REQ_READY = 1'b0;
                mem_stall--;
            end else begin
                MEM_REQ_READY = mem_rand ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
    end

    // L1 sink backpressure.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            DATA_TO_L1_READY = l1_block ? 1'b0 : (l1_rand ? ($urandom_range(1) == 1) : 1'b1);
        end
    end

    // Monitor: expectations are pushed at the address handshake and popped when the DUT presents output.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                busy        = 1'b0;
                req_stalled = 1'b0;
                blk_stalled = 1'b0;
                crit_due    = 1'b0;
                blk_q.delete();
                req_q.delete();
                crit_q.delete();
            end else begin
                check("l1_ready_vs_busy", BW'(ADDRESS_FROM_L1_READY), BW'(!busy));

                if (ADDRESS_FROM_L1_VALID && ADDRESS_FROM_L1_READY) begin
                    logic [WAW-1:0] base;
                    logic [BW-1:0]  blk;
                    int unsigned    off;
                    base = ADDRESS_FROM_L1 & ~WAW'(WPB - 1);
`ifdef CRITICAL_WORD_FIRST_EN
                    off = int'(ADDRESS_FROM_L1[3:0]);
`else
                    off = 0;
`endif
                    for (int unsigned k = 0; k < WPB; k++) begin
                        req_q.push_back(base + WAW'((off + k) % WPB));
                        blk[k*DW +: DW] = mem_word(base + WAW'(k));
                    end
                    blk_q.push_back(blk);
                    crit_q.push_back(mem_word(base + WAW'(off)));
                    busy      = 1'b1;
                    tb_issued = 0;
                    tb_recv   = 0;
                    hs_cyc    = cyc;
                    lat_seen  = 1'b0;
                end

                if (req_stalled) begin
                    check("req_hold_valid", BW'(MEM_REQ_VALID), BW'(1));
                    check("req_hold_addr", BW'(MEM_REQ_ADDRESS), BW'(req_prev));
                end
                if (MEM_REQ_VALID && MEM_REQ_READY) begin
                    resp_t r;
                    check("outstanding_limit", BW'((tb_issued - tb_recv) < int'(MAXO)), BW'(1));
                    if (req_q.size() == 0) begin
                        timeout_fail("unexpected_mem_request");
                    end else begin
                        check("mem_req_addr", BW'(MEM_REQ_ADDRESS), BW'(req_q.pop_front()));
                    end
                    r.due  = cyc + 1 + (resp_rand ? $urandom_range(3) : resp_delay);
                    r.data = mem_word(MEM_REQ_ADDRESS);
                    resp_q.push_back(r);
                    tb_issued++;
                end
                req_stalled = MEM_REQ_VALID && !MEM_REQ_READY;
                req_prev    = MEM_REQ_ADDRESS;

`ifdef CRITICAL_WORD_FIRST_EN
                check("crit_pulse", BW'(CRITICAL_WORD_VALID), BW'(crit_due));
                if (CRITICAL_WORD_VALID) begin
                    if (crit_q.size() == 0) timeout_fail("unexpected_critical_word");
                    else check("critical_word", BW'(CRITICAL_WORD), BW'(crit_q.pop_front()));
                end
`endif
                crit_due = busy && MEM_RESP_VALID && (tb_recv == 0);
                if (MEM_RESP_VALID) tb_recv++;

                if (blk_stalled) begin
                    check("blk_hold_valid", BW'(DATA_TO_L1_VALID), BW'(1));
                    check("blk_hold_data", DATA_TO_L1, blk_prev);
                end
                if (DATA_TO_L1_VALID && !lat_seen) begin
                    lat_seen = 1'b1;
                    if (lat_chk) check("refill_latency", BW'(cyc - hs_cyc), BW'(WPB + 2));
                end
                if (DATA_TO_L1_VALID && DATA_TO_L1_READY) begin
                    if (blk_q.size() == 0) timeout_fail("unexpected_block");
                    else check("block_data", DATA_TO_L1, blk_q.pop_front());
                    busy = 1'b0;
`ifndef CRITICAL_WORD_FIRST_EN
                    void'(crit_q.pop_front());
`endif
                end
                blk_stalled = DATA_TO_L1_VALID && !DATA_TO_L1_READY;
                blk_prev    = DATA_TO_L1;
            end
        end
    end

    task automatic send_miss(input logic [WAW-1:0] a);
        int n = 0;
        @(posedge CLK);
        #1;
        ADDRESS_FROM_L1       = a;
        ADDRESS_FROM_L1_VALID = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (!(ADDRESS_FROM_L1_READY && RST_N) && n < 2000);
        if (!(ADDRESS_FROM_L1_READY && RST_N)) timeout_fail("miss_accept");
        @(posedge CLK);
        #1;
        ADDRESS_FROM_L1_VALID = 1'b0;
        ADDRESS_FROM_L1       = WAW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || blk_q.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (busy || blk_q.size() != 0) timeout_fail("wait_idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr_ready"}, BW'(ADDRESS_FROM_L1_READY), BW'(1));
        check({tag, "_blk_valid"}, BW'(DATA_TO_L1_VALID), BW'(0));
        check({tag, "_req_valid"}, BW'(MEM_REQ_VALID), BW'(0));
        check({tag, "_req_addr"}, BW'(MEM_REQ_ADDRESS), BW'(0));
        check({tag, "_blk_data"}, DATA_TO_L1, BW'(0));
`ifdef CRITICAL_WORD_FIRST_EN
        check({tag, "_crit_valid"}, BW'(CRITICAL_WORD_VALID), BW'(0));
        check({tag, "_crit_word"}, BW'(CRITICAL_WORD), BW'(0));
`endif
    endtask

    initial begin
        int n;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("por");
        #1;
        RST_N = 1'b1;

        // Zero-wait refill with latency measurement.
        lat_chk = 1'b1;
        send_miss(WAW'(32'h123));
        wait_idle(300);
        lat_chk = 1'b0;

        // Critical-word-style offset in the middle of a block.
        send_miss(WAW'(32'h127));
        wait_idle(300);

        // Memory request stall mid-fill.
        send_miss(WAW'($urandom));
        n = 0;
        while (tb_issued < 5 && n < 200) begin @(negedge CLK); n++; end
        if (tb_issued < 5) timeout_fail("stall_setup");
        mem_stall = 5;
        wait_idle(300);

        // L1 holds off the block for ten cycles.
        l1_block = 1'b1;
        send_miss(WAW'($urandom));
        n = 0;
        while (!DATA_TO_L1_VALID && n < 300) begin @(negedge CLK); n++; end
        if (!DATA_TO_L1_VALID) timeout_fail("deliver_wait");
        repeat (10) @(negedge CLK);
        l1_block = 1'b0;
        wait_idle(50);

        // Slow memory exercises the outstanding limit.
        resp_delay = 8;
        send_miss(WAW'($urandom));
        wait_idle(1000);
        resp_delay = 0;

        // Reset in the middle of a fill, stale responses arrive afterwards.
        resp_delay = 2;
        send_miss(WAW'(32'h3456));
        n = 0;
        while (tb_recv < 6 && n < 300) begin @(negedge CLK); n++; end
        if (tb_recv < 6) timeout_fail("reset_setup");
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midfill");
        repeat (2) @(negedge CLK);
        #2;
        RST_N = 1'b1;
        resp_delay = 0;
        n = 0;
        while (resp_q.size() != 0 && n < 100) begin @(negedge CLK); n++; end
        if (resp_q.size() != 0) timeout_fail("stale_drain");
        repeat (2) @(negedge CLK);
        send_miss(WAW'(32'h0ABC));
        wait_idle(300);

        // Back-to-back misses: second request held while the first is delivered.
        l1_block = 1'b1;
        send_miss(WAW'(32'h0040));
        fork
            send_miss(WAW'(32'h0F3D));
            begin
                n = 0;
                while (!DATA_TO_L1_VALID && n < 300) begin @(negedge CLK); n++; end
                if (!DATA_TO_L1_VALID) timeout_fail("b2b_deliver_wait");
                repeat (3) @(negedge CLK);
                l1_block = 1'b0;
            end
        join
        wait_idle(300);

        // Randomized traffic on every handshake.
        mem_rand  = 1'b1;
        resp_rand = 1'b1;
        l1_rand   = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_miss(WAW'($urandom));
            if ($urandom_range(1) == 1) wait_idle(1000);
        end
        wait_idle(1000);

        check("blk_queue_empty", BW'(blk_q.size()), BW'(0));
        check("req_queue_empty", BW'(req_q.size()), BW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
